// File: rtl/bf_pkg.sv
// Shared widths, register index constants and writeback FSM state encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bf_pkg;

   localparam int XLEN      = 64;
   localparam int NUM_REGS  = 16;
   localparam int REG_IDX_W = 4;

   localparam logic [REG_IDX_W-1:0] RAX = 4'd0;
   localparam logic [REG_IDX_W-1:0] RDX = 4'd2;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      SPECIAL = 2'd1,
      DRAIN   = 2'd2,
      HALTED  = 2'd3
   } wb_state_t;

endpackage

// File: rtl/writeback_regfile_if.sv
// Bundles the writeback, reservation, operand-read and status signals.
// Latency: n/a (wiring only).
// Backpressure: wb_ready / rsv_ready are driven by the slave side.
interface writeback_regfile_if;
   import bf_pkg::*;

   logic                  wb_valid;
   logic                  wb_ready;
   logic [REG_IDX_W-1:0]  wb_dest_reg;
   logic [XLEN-1:0]       wb_result;
   logic                  wb_special_valid;
   logic [REG_IDX_W-1:0]  wb_special_reg;
   logic [XLEN-1:0]       wb_result_special;
   logic                  wb_halt;

   logic                  rsv_valid;
   logic [REG_IDX_W-1:0]  rsv_reg;
   logic                  rsv_ready;

   logic [REG_IDX_W-1:0]  rd_reg_a;
   logic [REG_IDX_W-1:0]  rd_reg_b;
   logic [XLEN-1:0]       rd_val_a;
   logic [XLEN-1:0]       rd_val_b;

   logic [NUM_REGS-1:0]   busy;
   logic                  halted;

   modport master (
      output wb_valid, wb_dest_reg, wb_result, wb_special_valid,
             wb_special_reg, wb_result_special, wb_halt,
             rsv_valid, rsv_reg, rd_reg_a, rd_reg_b,
      input  wb_ready, rsv_ready, rd_val_a, rd_val_b, busy, halted
   );

   modport slave (
      input  wb_valid, wb_dest_reg, wb_result, wb_special_valid,
             wb_special_reg, wb_result_special, wb_halt,
             rsv_valid, rsv_reg, rd_reg_a, rd_reg_b,
      output wb_ready, rsv_ready, rd_val_a, rd_val_b, busy, halted
   );

endinterface

// File: rtl/writeback_regfile_array.sv
// 16x64 register storage: one synchronous write port, two combinational read ports.
// Latency: write visible on the array outputs the cycle after the edge; reads are 0-cycle.
// Backpressure: none; the write port accepts every cycle.
module regfile_array
   import bf_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  we,
   input  logic [REG_IDX_W-1:0]  waddr,
   input  logic [XLEN-1:0]       wdata,
   input  logic [REG_IDX_W-1:0]  raddr_a,
   input  logic [REG_IDX_W-1:0]  raddr_b,
   output logic [XLEN-1:0]       rdata_a,
   output logic [XLEN-1:0]       rdata_b
);

   logic [XLEN-1:0] mem [NUM_REGS];

   // Clear every entry on reset, otherwise perform the single write.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            mem[i] <= '0;
         end
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata_a = mem[raddr_a];
   assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/writeback_regfile.sv
// Writeback stage: register file with scoreboard, write bypass and halt/drain sequencing.
// Latency: writes land at the accepting edge; reads bypass the in-flight write combinationally.
// Backpressure: wb_ready drops for the cycle after a dual-result item and once halted; rsv_ready stalls on WAW.
module writeback_regfile
   import bf_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   writeback_regfile_if.slave   bus
);

   wb_state_t              state_q;
   logic                   wb_ready_q;
   logic                   rsv_open_q;
   logic                   halted_q;
   logic [REG_IDX_W-1:0]   spec_reg_q;
   logic [XLEN-1:0]        spec_val_q;
   logic [NUM_REGS-1:0]    busy_q;
   logic [NUM_REGS-1:0]    busy_nxt;

   logic                   wb_fire;
   logic                   rsv_ready_c;
   logic                   rsv_fire;
   logic                   we;
   logic [REG_IDX_W-1:0]   waddr;
   logic [XLEN-1:0]        wdata;
   logic [XLEN-1:0]        arr_a;
   logic [XLEN-1:0]        arr_b;

   assign wb_fire     = bus.wb_valid & wb_ready_q;
   assign rsv_ready_c = rsv_open_q & ~busy_q[bus.rsv_reg];
   assign rsv_fire    = bus.rsv_valid & rsv_ready_c;

   // Pick the one write this cycle: the latched second result owns the port in SPECIAL.
   always_comb begin
      we    = 1'b0;
      waddr = '0;
      wdata = '0;
      if (state_q == SPECIAL) begin
         we    = 1'b1;
         waddr = spec_reg_q;
         wdata = spec_val_q;
      end else if (wb_fire && !bus.wb_halt) begin
         we    = 1'b1;
         waddr = bus.wb_dest_reg;
         wdata = bus.wb_result;
      end
   end

   // Scoreboard update: a write clears its bit, a reservation sets one; set is applied last so it wins.
   always_comb begin
      busy_nxt = busy_q;
      if (we) begin
         busy_nxt[waddr] = 1'b0;
      end
      if (rsv_fire) begin
         busy_nxt[bus.rsv_reg] = 1'b1;
      end
   end

   // Scoreboard register.
   always_ff @(posedge clk) begin
      if (reset) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_nxt;
      end
   end

   // Writeback FSM; ready/halted flags are registered alongside the state they belong to.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= RUN;
         wb_ready_q <= 1'b1;
         rsv_open_q <= 1'b1;
         halted_q   <= 1'b0;
         spec_reg_q <= '0;
         spec_val_q <= '0;
      end else begin
         case (state_q)
            RUN: begin
               if (wb_fire && bus.wb_halt) begin
                  state_q    <= DRAIN;
                  rsv_open_q <= 1'b0;
               end else if (wb_fire && bus.wb_special_valid) begin
                  state_q    <= SPECIAL;
                  wb_ready_q <= 1'b0;
                  spec_reg_q <= bus.wb_special_reg;
                  spec_val_q <= bus.wb_result_special;
               end
            end
            SPECIAL: begin
               state_q    <= RUN;
               wb_ready_q <= 1'b1;
            end
            DRAIN: begin
               if (busy_q == '0) begin
                  state_q    <= HALTED;
                  wb_ready_q <= 1'b0;
                  halted_q   <= 1'b1;
               end
            end
            HALTED: begin
               state_q <= HALTED;
            end
         endcase
      end
   end

   regfile_array u_array (
      .clk     (clk),
      .reset   (reset),
      .we      (we),
      .waddr   (waddr),
      .wdata   (wdata),
      .raddr_a (bus.rd_reg_a),
      .raddr_b (bus.rd_reg_b),
      .rdata_a (arr_a),
      .rdata_b (arr_b)
   );

   // Reads see the value being written this cycle.
   assign bus.rd_val_a  = (we && waddr == bus.rd_reg_a) ? wdata : arr_a;
   assign bus.rd_val_b  = (we && waddr == bus.rd_reg_b) ? wdata : arr_b;
   assign bus.wb_ready  = wb_ready_q;
   assign bus.rsv_ready = rsv_ready_c;
   assign bus.busy      = busy_q;
   assign bus.halted    = halted_q;

endmodule

// File: tb/tb_writeback_regfile.sv
// Directed bench for writeback_regfile with a cycle-level reference model and literal spot checks.
module tb_writeback_regfile;
   import bf_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b1;
   bit   started = 1'b0;
   int   tests = 0;
   int   fails = 0;

   writeback_regfile_if bus ();

   writeback_regfile dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   logic [63:0] m_regs [16];
   logic [15:0] m_busy = '0;
   logic        m_spec_pend = 1'b0;
   logic [3:0]  m_spec_reg = '0;
   logic [63:0] m_spec_val = '0;
   logic        m_draining = 1'b0;
   logic        m_halted = 1'b0;

   function automatic logic exp_wb_ready();
      return !m_halted && !m_spec_pend;
   endfunction

   function automatic logic exp_rsv_ready();
      return !m_halted && !m_draining && !m_busy[bus.rsv_reg];
   endfunction

   function automatic logic [63:0] exp_rd(input logic [3:0] idx);
      if (m_spec_pend && idx == m_spec_reg) return m_spec_val;
      if (bus.wb_valid && exp_wb_ready() && !bus.wb_halt && idx == bus.wb_dest_reg)
         return bus.wb_result;
      return m_regs[idx];
   endfunction

   always @(posedge clk) begin : model_upd
      logic        fire;
      logic        rfire;
      logic [15:0] nb;
      if (reset) begin
         for (int i = 0; i < 16; i++) m_regs[i] <= '0;
         m_busy      <= '0;
         m_spec_pend <= 1'b0;
         m_spec_reg  <= '0;
         m_spec_val  <= '0;
         m_draining  <= 1'b0;
         m_halted    <= 1'b0;
      end else begin
         fire  = bus.wb_valid && exp_wb_ready();
         rfire = bus.rsv_valid && exp_rsv_ready();
         nb    = m_busy;
         if (m_spec_pend) begin
            m_regs[m_spec_reg] <= m_spec_val;
            nb[m_spec_reg] = 1'b0;
            m_spec_pend <= 1'b0;
         end else if (fire && !bus.wb_halt) begin
            m_regs[bus.wb_dest_reg] <= bus.wb_result;
            nb[bus.wb_dest_reg] = 1'b0;
            if (bus.wb_special_valid && !m_draining) begin
               m_spec_pend <= 1'b1;
               m_spec_reg  <= bus.wb_special_reg;
               m_spec_val  <= bus.wb_result_special;
            end
         end
         if (m_draining && m_busy == 16'h0) begin
            m_draining <= 1'b0;
            m_halted   <= 1'b1;
         end else if (fire && bus.wb_halt && !m_draining) begin
            m_draining <= 1'b1;
         end
         if (rfire) nb[bus.rsv_reg] = 1'b1;
         m_busy <= nb;
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      if (started && !reset) begin
         chk("cyc_wb_ready",  {63'd0, bus.wb_ready},  {63'd0, exp_wb_ready()});
         chk("cyc_rsv_ready", {63'd0, bus.rsv_ready}, {63'd0, exp_rsv_ready()});
         chk("cyc_rd_val_a",  bus.rd_val_a, exp_rd(bus.rd_reg_a));
         chk("cyc_rd_val_b",  bus.rd_val_b, exp_rd(bus.rd_reg_b));
         chk("cyc_busy",      {48'd0, bus.busy}, {48'd0, m_busy});
         chk("cyc_halted",    {63'd0, bus.halted}, {63'd0, m_halted});
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.wb_valid          = 1'b0;
      bus.wb_special_valid  = 1'b0;
      bus.wb_halt           = 1'b0;
      bus.rsv_valid         = 1'b0;
   endtask

   task automatic wb(input logic [3:0] d, input logic [63:0] v);
      bus.wb_valid         = 1'b1;
      bus.wb_dest_reg      = d;
      bus.wb_result        = v;
      bus.wb_special_valid = 1'b0;
      bus.wb_halt          = 1'b0;
   endtask

   task automatic rsv(input logic [3:0] r);
      bus.rsv_valid = 1'b1;
      bus.rsv_reg   = r;
   endtask

   initial begin
      idle();
      bus.wb_dest_reg       = '0;
      bus.wb_result         = '0;
      bus.wb_special_reg    = '0;
      bus.wb_result_special = '0;
      bus.rsv_reg           = '0;
      bus.rd_reg_a          = 4'd7;
      bus.rd_reg_b          = 4'd0;
      repeat (2) @(posedge clk);
      #1;
      reset   = 1'b0;
      started = 1'b1;
      #2;
      chk("rst_busy",     {48'd0, bus.busy}, 64'h0);
      chk("rst_halted",   {63'd0, bus.halted}, 64'h0);
      chk("rst_wb_ready", {63'd0, bus.wb_ready}, 64'h1);
      chk("rst_reg7",     bus.rd_val_a, 64'h0);

      // Reserve r3 then write it: bypass same cycle, busy 1 -> 0.
      step(); rsv(4'd3); #2;
      chk("r3_rsv_ready", {63'd0, bus.rsv_ready}, 64'h1);
      step(); idle(); wb(4'd3, 64'h1234); bus.rd_reg_a = 4'd3; #2;
      chk("r3_busy_set", {48'd0, bus.busy}, 64'h0008);
      chk("r3_bypass",   bus.rd_val_a, 64'h1234);
      step(); idle(); #2;
      chk("r3_busy_clr", {48'd0, bus.busy}, 64'h0);
      chk("r3_stored",   bus.rd_val_a, 64'h1234);

      // MUL: rax=5, rdx=0xFFFF.
      step(); rsv(RAX);
      step(); rsv(RDX);
      step(); idle();
      wb(RAX, 64'h5);
      bus.wb_special_valid  = 1'b1;
      bus.wb_special_reg    = RDX;
      bus.wb_result_special = 64'hFFFF;
      bus.rd_reg_a = RAX; bus.rd_reg_b = RDX; #2;
      chk("mul_busy_pre", {48'd0, bus.busy}, 64'h0005);
      step(); idle(); #2;
      chk("mul_stall",    {63'd0, bus.wb_ready}, 64'h0);
      chk("mul_rax",      bus.rd_val_a, 64'h5);
      chk("mul_rdx_byp",  bus.rd_val_b, 64'hFFFF);
      chk("mul_busy_mid", {48'd0, bus.busy}, 64'h0004);
      step(); #2;
      chk("mul_ready",    {63'd0, bus.wb_ready}, 64'h1);
      chk("mul_busy_end", {48'd0, bus.busy}, 64'h0);
      chk("mul_rdx",      bus.rd_val_b, 64'hFFFF);

      // Same index for primary and second result: second wins.
      wb(4'd4, 64'hAAAA);
      bus.wb_special_valid  = 1'b1;
      bus.wb_special_reg    = 4'd4;
      bus.wb_result_special = 64'hBBBB;
      bus.rd_reg_a = 4'd4;
      step(); idle();
      step(); #2;
      chk("same_idx", bus.rd_val_a, 64'hBBBB);

      // WAW stall on r5, then write and reservation of r5 on one edge.
      rsv(4'd5);
      step(); #2;
      chk("r5_stall", {63'd0, bus.rsv_ready}, 64'h0);
      step(); bus.rsv_valid = 1'b0; wb(4'd5, 64'h55);
      step(); wb(4'd5, 64'h66); rsv(4'd5); bus.rd_reg_b = 4'd5; #2;
      chk("r5_rsv_open", {63'd0, bus.rsv_ready}, 64'h1);
      step(); idle(); #2;
      chk("r5_set_wins", {48'd0, bus.busy}, 64'h0020);
      chk("r5_val",      bus.rd_val_b, 64'h66);
      wb(4'd5, 64'h77);
      step(); idle();

      // Reset while the second result is pending.
      wb(4'd6, 64'h11);
      bus.wb_special_valid  = 1'b1;
      bus.wb_special_reg    = 4'd7;
      bus.wb_result_special = 64'h22;
      bus.rd_reg_a = 4'd6; bus.rd_reg_b = 4'd7;
      step(); idle(); reset = 1'b1;
      step(); reset = 1'b0; #2;
      chk("rstsp_r6",    bus.rd_val_a, 64'h0);
      chk("rstsp_r7",    bus.rd_val_b, 64'h0);
      chk("rstsp_ready", {63'd0, bus.wb_ready}, 64'h1);
      step(); #2;
      chk("rstsp_r7_after", bus.rd_val_b, 64'h0);

      // Halt with r1 outstanding, drain, then halted.
      rsv(4'd1);
      step(); idle();
      wb(4'd8, 64'h99); bus.wb_halt = 1'b1; bus.rd_reg_a = 4'd8;
      step(); idle(); bus.rsv_reg = 4'd9; bus.rsv_valid = 1'b1; #2;
      chk("drain_wb_ready",  {63'd0, bus.wb_ready}, 64'h1);
      chk("drain_rsv_ready", {63'd0, bus.rsv_ready}, 64'h0);
      chk("halt_no_write",   bus.rd_val_a, 64'h0);
      wb(4'd1, 64'h42);
      step(); idle(); #2;
      chk("drain_busy",   {48'd0, bus.busy}, 64'h0);
      chk("drain_halted", {63'd0, bus.halted}, 64'h0);
      step(); #2;
      chk("halted",          {63'd0, bus.halted}, 64'h1);
      chk("halted_wb_ready", {63'd0, bus.wb_ready}, 64'h0);
      wb(4'd10, 64'hDEAD); bus.rd_reg_a = 4'd10;
      step(); step(); idle(); #2;
      chk("halted_no_write", bus.rd_val_a, 64'h0);
      chk("halted_hold",     {63'd0, bus.halted}, 64'h1);

      step();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
